// File: rtl/board_scan_checker.sv
// ============================================================================
// Module   : board_scan_checker
// Brief    : Sequential 4x4 Sudoku validator. Scans 4 rows, 4 columns and
//            4 boxes through a group checker and accumulates a verdict.
//            Optional macro BOARD_EARLY_EXIT_EN ends the scan on first failure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module group_checker (
    input  logic [15:0] i_group,
    output logic        o_valid
);
    logic [3:0] w_seen;
    logic       w_in_range;

    // Four in-range digits covering all of 1..4 can only be a permutation.
    always_comb begin
        w_seen     = 4'b0000;
        w_in_range = 1'b1;
        for (int k = 0; k < 4; k++) begin
            case (i_group[k*4 +: 4])
                4'd1:    w_seen[0] = 1'b1;
                4'd2:    w_seen[1] = 1'b1;
                4'd3:    w_seen[2] = 1'b1;
                4'd4:    w_seen[3] = 1'b1;
                default: w_in_range = 1'b0;
            endcase
        end
    end

    assign o_valid = w_in_range && (w_seen == 4'b1111);
endmodule

module board_scan_checker #(
    parameter int STALL_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] boardDigits,
    output logic        busy,
    output logic        done,
    output logic        boardCorrect,
    output logic [3:0]  failCount,
    output logic [3:0]  firstFail,
    output logic [15:0] groupDigits,
    output logic [3:0]  groupIdx
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_STALL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] c_last_group = 4'd11;
    localparam logic [3:0] c_no_fail    = 4'hF;
    localparam logic [3:0] c_stall_last = 4'(STALL_CYCLES - 1);
    localparam bit         c_has_stall  = (STALL_CYCLES > 0);

    state_t      r_state_q,      w_state_d;
    logic [63:0] r_board_q,      w_board_d;
    logic        r_busy_q,       w_busy_d;
    logic        r_done_q,       w_done_d;
    logic        r_correct_q,    w_correct_d;
    logic [3:0]  r_fail_cnt_q,   w_fail_cnt_d;
    logic [3:0]  r_first_fail_q, w_first_fail_d;
    logic [3:0]  r_group_idx_q,  w_group_idx_d;
    logic [3:0]  r_stall_cnt_q,  w_stall_cnt_d;

    logic        w_group_ok;
    logic        w_last;
    logic        w_exit;

    // Cell index {r,c} of element k in group idx; boxes map to {b[1],k[1]},{b[0],k[0]}.
    function automatic logic [3:0] cell_of(input logic [3:0] idx, input logic [1:0] k);
        logic [1:0] r;
        logic [1:0] c;
        if (idx < 4'd4) begin
            r = idx[1:0];
            c = k;
        end else if (idx < 4'd8) begin
            r = k;
            c = idx[1:0];
        end else begin
            r = {idx[1], k[1]};
            c = {idx[0], k[0]};
        end
        return {r, c};
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_elem
        logic [3:0] w_cell;
        assign w_cell                = cell_of(r_group_idx_q, 2'(k));
        assign groupDigits[k*4 +: 4] = r_board_q[{w_cell, 2'b00} +: 4];
    end

    group_checker u_group_checker (
        .i_group (groupDigits),
        .o_valid (w_group_ok)
    );

    assign w_last = (r_group_idx_q == c_last_group);
`ifdef BOARD_EARLY_EXIT_EN
    assign w_exit = w_last || !w_group_ok;
`else
    assign w_exit = w_last;
`endif

    always_comb begin
        w_state_d      = r_state_q;
        w_board_d      = r_board_q;
        w_busy_d       = r_busy_q;
        w_done_d       = 1'b0;
        w_correct_d    = r_correct_q;
        w_fail_cnt_d   = r_fail_cnt_q;
        w_first_fail_d = r_first_fail_q;
        w_group_idx_d  = r_group_idx_q;
        w_stall_cnt_d  = r_stall_cnt_q;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_board_d      = boardDigits;
                    w_fail_cnt_d   = 4'd0;
                    w_first_fail_d = c_no_fail;
                    w_group_idx_d  = 4'd0;
                    w_busy_d       = 1'b1;
                    w_state_d      = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!w_group_ok) begin
                    w_fail_cnt_d = r_fail_cnt_q + 4'd1;
                    if (r_first_fail_q == c_no_fail) begin
                        w_first_fail_d = r_group_idx_q;
                    end
                end
                if (w_exit) begin
                    w_state_d   = S_DONE;
                    w_busy_d    = 1'b0;
                    w_done_d    = 1'b1;
                    w_correct_d = (w_fail_cnt_d == 4'd0);
                end else if (c_has_stall) begin
                    w_state_d     = S_STALL;
                    w_stall_cnt_d = 4'd0;
                end else begin
                    w_group_idx_d = r_group_idx_q + 4'd1;
                end
            end
            S_STALL: begin
                if (r_stall_cnt_q == c_stall_last) begin
                    w_group_idx_d = r_group_idx_q + 4'd1;
                    w_state_d     = S_SCAN;
                end else begin
                    w_stall_cnt_d = r_stall_cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= S_IDLE;
            r_board_q      <= 64'd0;
            r_busy_q       <= 1'b0;
            r_done_q       <= 1'b0;
            r_correct_q    <= 1'b0;
            r_fail_cnt_q   <= 4'd0;
            r_first_fail_q <= c_no_fail;
            r_group_idx_q  <= 4'd0;
            r_stall_cnt_q  <= 4'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_board_q      <= w_board_d;
            r_busy_q       <= w_busy_d;
            r_done_q       <= w_done_d;
            r_correct_q    <= w_correct_d;
            r_fail_cnt_q   <= w_fail_cnt_d;
            r_first_fail_q <= w_first_fail_d;
            r_group_idx_q  <= w_group_idx_d;
            r_stall_cnt_q  <= w_stall_cnt_d;
        end
    end

    assign busy         = r_busy_q;
    assign done         = r_done_q;
    assign boardCorrect = r_correct_q;
    assign failCount    = r_fail_cnt_q;
    assign firstFail    = r_first_fail_q;
    assign groupIdx     = r_group_idx_q;
endmodule

`default_nettype wire
